// File: rtl/freq_div_ctrl.sv
// Run/ratio controller for the /2../16 clock divider: owns the divider counter and
// swaps the output ratio only at the all-ones wrap so DOUT never emits a runt period.
module freq_div_ctrl #(
    parameter int SEL_W = 2
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             EN,
    input  logic             REQ_VALID,
    input  logic [SEL_W-1:0] REQ_SEL,
    output logic             REQ_READY,
    output logic [SEL_W-1:0] ACTIVE_SEL,
    output logic             BUSY,
    output logic             DOUT,
    output logic             TICK
);
    localparam int CW = 2**SEL_W;

    typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [SEL_W-1:0]  active_q, active_d;
    logic [SEL_W-1:0]  pend_q, pend_d;
    logic [CW-1:0]     tick_mask;
    logic              xfer;
    logic              boundary;

    assign REQ_READY = (state_q != PEND);
    assign xfer      = REQ_VALID & REQ_READY;
    assign boundary  = &cnt_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            active_q <= '0;
            pend_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
            pend_q   <= pend_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        pend_d   = pend_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (xfer) active_d = REQ_SEL;
                // cnt stays 0 into RUN so the first counting cycle shows cnt = 0
                if (EN) state_d = RUN;
            end
            RUN: begin
                if (!EN) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    if (xfer) active_d = REQ_SEL;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (xfer) begin
                        if (boundary) begin
                            active_d = REQ_SEL;
                        end else begin
                            pend_d  = REQ_SEL;
                            state_d = PEND;
                        end
                    end
                end
            end
            PEND: begin
                if (!EN) begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    active_d = pend_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (boundary) begin
                        active_d = pend_q;
                        state_d  = RUN;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // bits [ACTIVE_SEL:0] of cnt; all ones there marks the last cycle of a divided period
    always_comb begin
        tick_mask = '0;
        for (int i = 0; i < CW; i++) tick_mask[i] = (i <= int'(active_q));
    end

    assign ACTIVE_SEL = active_q;
    assign BUSY       = (state_q == PEND);
    assign DOUT       = (state_q != IDLE) && cnt_q[active_q];
    assign TICK       = (state_q != IDLE) && (&(cnt_q | ~tick_mask));

endmodule

// File: doc/freq_div_ctrl.md
# freq_div_ctrl

Run/ratio controller for the divide-by-2/4/8/16 clock-divider datapath. Owns a synchronous divider counter and selects which divided output is driven. Accepts ratio-change requests over a valid/ready handshake and applies them only at the common wrap boundary, so `DOUT` never glitches or emits a runt period. Sits between the configuration logic and any consumer of `DOUT` or the `TICK` clock-enable.

## Interface
- `SEL_W`, default 2: width of ratio select. Counter width is `CW = 2**SEL_W` (4 at default). Divide ratio is `2**(sel+1)`.
- `CLK`  in  1  clock; all logic on rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `EN`  in  1  run enable; 1 = count, 0 = idle.
- `REQ_VALID`  in  1  ratio-change request valid.
- `REQ_SEL`  in  SEL_W  requested ratio: 0 = /2, 1 = /4, 2 = /8, 3 = /16.
- `REQ_READY`  out  1  controller can accept a request.
- `ACTIVE_SEL`  out  SEL_W  ratio currently driving `DOUT`/`TICK`.
- `BUSY`  out  1  a request is pending until the next boundary.
- `DOUT`  out  1  divided clock output, equal to `cnt[ACTIVE_SEL]`.
- `TICK`  out  1  one-cycle enable at the last cycle of each divided period.

## Operation
- State machine with three states.
  - IDLE: `cnt` held at 0; `DOUT = 0`; `TICK = 0`.
  - RUN: `cnt` increments by 1 each cycle, mod `2**CW`.
  - PEND: as RUN, with a new ratio latched in `pend_sel`.
- Transitions:
  - IDLE → RUN when `EN = 1`. The first count cycle has `cnt = 0`.
  - RUN/PEND → IDLE when `EN = 0`. `cnt` clears to 0 at that edge.
  - Entering IDLE from PEND loads `ACTIVE_SEL <= pend_sel`.
  - RUN → PEND on a handshake when `cnt != all-ones`.
  - PEND → RUN at the edge where `cnt == all-ones` (boundary). `ACTIVE_SEL <= pend_sel` on the same edge.
- Handshake:
  - A transfer occurs when `REQ_VALID & REQ_READY`.
  - `REQ_READY = (state != PEND)`.
  - `REQ_SEL` is sampled only on a transfer.
  - `BUSY = (state == PEND)`.
- Immediate-apply cases:
  - Request accepted in IDLE: `ACTIVE_SEL` loads at that edge; state stays IDLE unless `EN = 1`.
  - Request accepted in RUN on a boundary cycle: applied at that same edge; no PEND.
- `EN = 0` takes priority over a simultaneous request. The request is still accepted and loaded into `ACTIVE_SEL`.
- `TICK = 1` in RUN/PEND when `cnt[ACTIVE_SEL:0]` is all ones. It is combinational from registers only.
- `DOUT` is 0 in IDLE. Otherwise it equals `cnt[ACTIVE_SEL]`, duty cycle 50%.
- At the boundary every bit of `cnt` is 1. The next value is 0, so every `DOUT` choice falls at the switch edge. This is the glitch-free guarantee.

## Timing
- Reset values:
  - state IDLE, `cnt = 0`, `ACTIVE_SEL = 0`, `pend_sel = 0`.
  - `REQ_READY = 1`, `BUSY = 0`, `DOUT = 0`, `TICK = 0`.
- `RESET` overrides `EN` and `REQ_VALID`. Asserting it mid-period or while pending discards the pending ratio.
- Latency, EN rise to first `DOUT` high: `2**ACTIVE_SEL` cycles after the first count cycle.
- Ratio-change latency: 1 to `2**CW` cycles, depending on `cnt` at acceptance.
- No combinational path from any input to any output, except `REQ_READY`, which depends on state only.
- While BUSY, a held `REQ_VALID` waits. It is accepted in the cycle after the boundary.

## Test plan
- Reset, then `EN = 1` with sel 0: `DOUT` toggles every cycle (0,1,0,1); `TICK` is high on every odd cycle.
- Reset, then write sel 1 in IDLE, then `EN = 1`:
  - `DOUT` = 0,0,1,1 repeating.
  - `TICK` high when `cnt[1:0] = 3`, every 4 cycles.
  - `ACTIVE_SEL = 1` one edge after the handshake.
- Running sel 3, request sel 0 at `cnt = 5`:
  - `REQ_READY` low and `BUSY = 1` from the next cycle.
  - `ACTIVE_SEL` stays 3 until the edge after `cnt = 15`, then becomes 0.
  - `DOUT` falls at that edge, then toggles at /2.
  - No `DOUT` high pulse shorter than its ratio.
- Request issued exactly at `cnt = 15`: applied at that edge; `BUSY` never asserts.
- `EN` dropped while PEND at `cnt = 9`:
  - Next edge: IDLE, `cnt = 0`, `DOUT = 0`, `ACTIVE_SEL = pend_sel`, `REQ_READY = 1`.
- `RESET` pulsed for one cycle at `cnt = 7` while PEND:
  - All outputs return to reset values at that edge.
  - Pending sel discarded; `ACTIVE_SEL = 0`.
